// File: rtl/operand_feeder_pkg.sv
// Shared constants and state encoding for the operand feeder.
package operand_feeder_pkg;

  localparam int WIDTH = 44;              // operand width, matches the adder
  localparam int BEAT  = 11;              // beat width
  localparam int NBEAT = WIDTH / BEAT;    // beats per operand
  localparam int CNT_W = $clog2(NBEAT);   // beat counter width

  // Collect x, collect y, hold a complete staged pair
  typedef enum logic [1:0] {
    S_X    = 2'd0,
    S_Y    = 2'd1,
    S_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/operand_feeder_assembler.sv
// Beat assembler: shifts little-endian beats into the x or y staging
// register and counts beats within the operand being collected.
module operand_feeder_assembler
  import operand_feeder_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_beat_en,   // a beat is transferred this cycle
  input  logic             i_sel_y,     // 1: beat belongs to y, 0: to x
  input  logic [BEAT-1:0]  i_data,
  input  logic             i_clear,     // flush or commit: empty the staging
  output logic [WIDTH-1:0] o_stage_x,
  output logic [WIDTH-1:0] o_stage_y,
  output logic             o_last       // current beat is the final one of an operand
);

  logic [CNT_W-1:0] r_cnt;
  logic [BEAT-1:0]  r_slot_x [NBEAT];
  logic [BEAT-1:0]  r_slot_y [NBEAT];

  assign o_last = (r_cnt == CNT_W'(NBEAT - 1));

  // Beat counter: advances per accepted beat, wraps after the last slot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat_en) begin
      r_cnt <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBEAT; gi++) begin : g_slot
      // Each slot captures the beat whose index matches the counter
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_slot_x[gi] <= '0;
          r_slot_y[gi] <= '0;
        end else if (i_clear) begin
          r_slot_x[gi] <= '0;
          r_slot_y[gi] <= '0;
        end else if (i_beat_en && (r_cnt == CNT_W'(gi))) begin
          if (i_sel_y) r_slot_y[gi] <= i_data;
          else         r_slot_x[gi] <= i_data;
        end
      end

      assign o_stage_x[gi*BEAT +: BEAT] = r_slot_x[gi];
      assign o_stage_y[gi*BEAT +: BEAT] = r_slot_y[gi];
    end
  endgenerate

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder: builds x/y pairs from a beat stream and presents them to
// the registered adder, flagging the cycle the adder output holds x+y.
module operand_feeder
  import operand_feeder_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BEAT-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sum_valid
);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_in_ready;
  logic             w_beat_en;
  logic             w_commit;
  logic             w_last;
  logic [WIDTH-1:0] w_stage_x;
  logic [WIDTH-1:0] w_stage_y;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_out_valid;
  logic             r_sum_valid;

  assign in_ready  = w_in_ready;
  assign x         = r_x;
  assign y         = r_y;
  assign out_valid = r_out_valid;
  assign sum_valid = r_sum_valid;

  operand_feeder_assembler u_assembler (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_beat_en (w_beat_en),
    .i_sel_y   (r_state == S_Y),
    .i_data    (in_data),
    .i_clear   (flush | w_commit),
    .o_stage_x (w_stage_x),
    .o_stage_y (w_stage_y),
    .o_last    (w_last)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_X;
    else          r_state <= w_state_next;
  end

  // Next state, beat acceptance and commit decision; flush overrides all
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = (r_state != S_FULL);
    w_beat_en    = in_valid & w_in_ready & ~flush;
    w_commit     = 1'b0;
    if (flush) begin
      w_state_next = S_X;
    end else begin
      case (r_state)
        S_X:     if (w_beat_en && w_last) w_state_next = S_Y;
        S_Y:     if (w_beat_en && w_last) w_state_next = S_FULL;
        S_FULL: begin
          if (!r_out_valid || out_ready) begin
            w_commit     = 1'b1;
            w_state_next = S_X;
          end
        end
        default: w_state_next = S_X;
      endcase
    end
  end

  // Presented pair, its valid flag and the sum strobe aligned with the adder
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_sum_valid <= 1'b0;
    end else begin
      if (w_commit) begin
        r_x <= w_stage_x;
        r_y <= w_stage_y;
      end
      r_out_valid <= w_commit | (r_out_valid & ~out_ready);
      r_sum_valid <= r_out_valid & out_ready;
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Scoreboard bench for operand_feeder with a registered adder model.
module tb_operand_feeder;
  import operand_feeder_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [BEAT-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             sum_valid;
  logic [WIDTH-1:0] s = '0;
  logic             rand_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [WIDTH-1:0] px;
    logic [WIDTH-1:0] py;
  } pair_t;

  logic [BEAT-1:0]  cur_beats [$];
  pair_t            pair_q [$];
  logic [WIDTH-1:0] sum_q [$];

  operand_feeder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_valid (sum_valid)
  );

  always #5 clock = ~clock;

  // Downstream registered adder
  always @(posedge clock) s <= x + y;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: accepted beats group into 8, low beat first
  task automatic model_accept(input logic [BEAT-1:0] d);
    pair_t p;
    cur_beats.push_back(d);
    if (cur_beats.size() == 2 * NBEAT) begin
      for (int i = 0; i < NBEAT; i++) begin
        p.px[i*BEAT +: BEAT] = cur_beats[i];
        p.py[i*BEAT +: BEAT] = cur_beats[NBEAT + i];
      end
      pair_q.push_back(p);
      cur_beats.delete();
    end
  endtask

  // Monitor: checks sums on sum_valid, pair contents on each handshake
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (sum_valid) begin
        if (sum_q.size() == 0) begin
          chk("unexpected_sum_valid", 64'(sum_valid), 64'd0);
        end else begin
          logic [WIDTH-1:0] es;
          es = sum_q.pop_front();
          chk("sum_s", 64'(s), 64'(es));
          $display("sum s=%h expected=%h", s, es);
        end
      end
      if (out_valid && out_ready) begin
        if (pair_q.size() == 0) begin
          chk("unexpected_pair", 64'(out_valid), 64'd0);
        end else begin
          pair_t p;
          logic [WIDTH-1:0] es;
          p = pair_q.pop_front();
          chk("pair_x", 64'(x), 64'(p.px));
          chk("pair_y", 64'(y), 64'(p.py));
          es = p.px + p.py;
          sum_q.push_back(es);
          $display("handshake x=%h y=%h", x, y);
        end
      end
    end
  end

  // Random out_ready, changed away from the monitor's sampling edge
  always begin
    @(posedge clock);
    #2;
    if (rand_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic set_ready(input logic v);
    @(posedge clock);
    #2;
    out_ready = v;
    @(negedge clock);
  endtask

  // Starts and ends at a negedge
  task automatic send_beat(input logic [BEAT-1:0] d);
    int waited = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    model_accept(d);
    @(negedge clock);
  endtask

  task automatic flush_with_beat(input logic [BEAT-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    cur_beats.delete();
    @(negedge clock);
  endtask

  task automatic send_pair(input logic [WIDTH-1:0] vx, input logic [WIDTH-1:0] vy);
    for (int i = 0; i < NBEAT; i++) send_beat(vx[i*BEAT +: BEAT]);
    for (int i = 0; i < NBEAT; i++) send_beat(vy[i*BEAT +: BEAT]);
  endtask

  task automatic drain();
    int n = 0;
    while ((pair_q.size() != 0 || sum_q.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    chk("drain_pending", 64'(pair_q.size() + sum_q.size()), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum_valid", 64'(sum_valid), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic pair: s = 12
    set_ready(1'b1);
    send_pair(44'd4, 44'd8);
    drain();

    // Full range wrap
    send_pair({WIDTH{1'b1}}, {WIDTH{1'b1}});
    drain();

    // Backpressure: two pairs buffered, second waits staged
    set_ready(1'b0);
    send_pair(44'd11, 44'd40);
    send_pair(44'd38, 44'd62);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_x", 64'(x), 64'd11);
    chk("bp_y", 64'(y), 64'd40);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    // Handshake and commit on the same edge
    set_ready(1'b1);
    @(posedge clock);
    #1;
    chk("simul_out_valid", 64'(out_valid), 64'd1);
    chk("simul_x", 64'(x), 64'd38);
    chk("simul_y", 64'(y), 64'd62);
    @(negedge clock);
    drain();

    // Flush with a beat on the same cycle
    set_ready(1'b0);
    send_pair(44'd21, 44'd22);
    for (int i = 0; i < 6; i++) send_beat(11'(3 + i));
    flush_with_beat(11'h155);
    chk("flush_x", 64'(x), 64'd21);
    chk("flush_y", 64'(y), 64'd22);
    chk("flush_out_valid", 64'(out_valid), 64'd1);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    send_pair(44'd4, 44'd5);
    set_ready(1'b1);
    drain();

    // Reset mid-pair with a pair presented
    set_ready(1'b0);
    send_pair(44'd100, 44'd200);
    for (int i = 0; i < 3; i++) send_beat(11'(50 + i));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_x", 64'(x), 64'd0);
    chk("mrst_y", 64'(y), 64'd0);
    chk("mrst_sum_valid", 64'(sum_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    cur_beats.delete();
    pair_q.delete();
    sum_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    set_ready(1'b1);
    send_pair(44'd7, 44'd9);
    drain();

    // Randomised traffic with random backpressure and occasional flushes
    rand_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      for (int b = 0; b < 2 * NBEAT; b++) begin
        if (cur_beats.size() > 0 && $urandom_range(0, 15) == 0)
          flush_with_beat(11'($urandom));
        send_beat(11'($urandom));
      end
    end
    rand_en = 1'b0;
    set_ready(1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
